// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Restoring division, one quotient bit per cycle, with single-cycle special cases.
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [4:0]        i_rd_addr,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic [4:0]        o_rd_addr
);

  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state, state_n;
  logic [1:0]         op_q;
  logic               neg1_q, neg2_q;
  logic [DATA_W-1:0]  quot_q, dvs_q, rem_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept_c, signed_op_c, div_zero_c, ovf_c, special_c;
  logic [DATA_W-1:0]  special_res_c, abs1_c, abs2_c, fix_res_c;
  logic [DATA_W:0]    shifted_c, diff_c;
  logic               ge_c, last_step_c, q_neg_c, r_neg_c;

  // Request decode and special-case detection on the raw operands
  always_comb begin
    accept_c    = (state == S_IDLE) && i_start && !i_flush;
    signed_op_c = !i_op[0];
    div_zero_c  = (i_rs2_data == '0);
    ovf_c       = signed_op_c && (i_rs1_data == MIN_NEG) && (i_rs2_data == ALL_ONES);
    special_c   = div_zero_c || ovf_c;
    if (div_zero_c)
      special_res_c = i_op[1] ? i_rs1_data : ALL_ONES;
    else
      special_res_c = i_op[1] ? '0 : MIN_NEG;
    abs1_c = (signed_op_c && i_rs1_data[DATA_W-1]) ? -i_rs1_data : i_rs1_data;
    abs2_c = (signed_op_c && i_rs2_data[DATA_W-1]) ? -i_rs2_data : i_rs2_data;
  end

  // Restoring step: guard bit keeps the trial subtract exact
  always_comb begin
    shifted_c   = {rem_q, quot_q[DATA_W-1]};
    diff_c      = shifted_c - {1'b0, dvs_q};
    ge_c        = (shifted_c >= {1'b0, dvs_q});
    last_step_c = (cnt_q == LAST_CNT);
  end

  // Sign correction of the magnitude result
  always_comb begin
    q_neg_c   = (op_q == 2'b00) && (neg1_q != neg2_q);
    r_neg_c   = (op_q == 2'b10) && neg1_q;
    if (op_q[1])
      fix_res_c = r_neg_c ? -rem_q : rem_q;
    else
      fix_res_c = q_neg_c ? -quot_q : quot_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Flush overrides every transition
  always_comb begin
    state_n = state;
    o_stall = accept_c || (state == S_CALC) || (state == S_FIX);
    if (i_flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (i_start) state_n = special_c ? S_DONE : S_CALC;
        S_CALC: if (last_step_c) state_n = S_FIX;
        S_FIX:  state_n = S_DONE;
        S_DONE: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q      <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      quot_q    <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      o_result  <= '0;
      o_rd_addr <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_valid <= (state_n == S_DONE);
      o_busy  <= (state_n != S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            op_q      <= i_op;
            neg1_q    <= i_rs1_data[DATA_W-1];
            neg2_q    <= i_rs2_data[DATA_W-1];
            quot_q    <= abs1_c;
            dvs_q     <= abs2_c;
            rem_q     <= '0;
            cnt_q     <= '0;
            o_rd_addr <= i_rd_addr;
            if (special_c) o_result <= special_res_c;
          end
        end
        S_CALC: begin
          quot_q <= {quot_q[DATA_W-2:0], ge_c};
          rem_q  <= ge_c ? diff_c[DATA_W-1:0] : shifted_c[DATA_W-1:0];
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          if (!i_flush) o_result <= fix_res_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic model plus scoreboard, latency and control checks.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        stall, busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_res[$];
  logic [4:0]  exp_rd[$];

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_flush(flush), .i_op(op),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_rd_addr(rd),
    .o_stall(stall), .o_busy(busy), .o_valid(valid),
    .o_result(result), .o_rd_addr(rd_out)
  );

  // RISC-V M-extension semantics with plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    case (f)
      2'b00: if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a; else return 32'(sa / sb);
      2'b01: return a / b;
      2'b10: if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0; else return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (exp_res.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: actual result=%h rd=%0d expected no pulse", result, rd_out);
      end else begin
        logic [31:0] er;
        logic [4:0]  ed;
        er = exp_res.pop_front();
        ed = exp_rd.pop_front();
        if (result !== er || rd_out !== ed) begin
          errors++;
          $display("FAIL result: actual=%h rd=%0d expected=%h rd=%0d", result, rd_out, er, ed);
        end
      end
    end
  end

  task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; op = f; rs1 = a; rs2 = b; rd = r;
    #1;
    chk("stall_accept_cycle", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; rs1 = ~a; rs2 = ~b; rd = ~r; op = ~f;
  endtask

  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    int n, lat;
    bit done;
    exp_res.push_back(model(f, a, b));
    exp_rd.push_back(r);
    lat = is_special(f, a, b) ? 1 : 34;
    launch(f, a, b, r);
    n = 0;
    done = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (valid) done = 1;
      else if (n == 1) begin
        chk("stall_in_calc", 32'(stall), 32'd1);
        chk("busy_in_calc", 32'(busy), 32'd1);
      end
    end
    if (!done) begin
      chk("valid_timeout", 32'd0, 32'd1);
      exp_res.delete();
      exp_rd.delete();
    end else begin
      chk("latency_edges", 32'(n), 32'(lat));
      chk("stall_low_in_done", 32'(stall), 32'd0);
      chk("busy_in_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("valid_one_pulse", 32'(valid), 32'd0);
    end
  endtask

  initial begin
    int nv;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0; rd = '0;

    // Model pinned against hand-computed values
    chk("model_divu_100_7", model(2'b01, 32'd100, 32'd7), 32'd14);
    chk("model_remu_100_7", model(2'b11, 32'd100, 32'd7), 32'd2);
    chk("model_div_m7_2", model(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem_m7_2", model(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_div_ovf", model(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("model_rem_by0", model(2'b10, 32'd5, 32'd0), 32'd5);

    @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_busy_valid_stall", {29'd0, busy, valid, stall}, 32'd0);
    rst = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 5'd5);
    run_op(2'b11, 32'd100, 32'd7, 5'd6);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8);
    run_op(2'b00, 32'd5, 32'd0, 5'd9);
    run_op(2'b10, 32'd5, 32'd0, 5'd10);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd13);
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 5'd14);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd15);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd17);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 5'd18);
    run_op(2'b01, 32'd0, 32'd3, 5'd19);

    // Flush while the counter holds 10
    launch(2'b01, 32'hFFFF_FFFF, 32'd3, 5'd20);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_keeps_result", result, model(2'b01, 32'd0, 32'd3));
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("flush_no_valid", 32'(nv), 32'd0);
    run_op(2'b01, 32'd9, 32'd3, 5'd21);

    // Asynchronous reset in the middle of CALC
    launch(2'b01, 32'd1000, 32'd10, 5'd22);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_rd", 32'(rd_out), 32'd0);
    chk("arst_busy_valid_stall", {29'd0, busy, valid, stall}, 32'd0);
    #1 rst = 1'b0;
    run_op(2'b00, 32'd1000, 32'hFFFF_FFF6, 5'd23);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_res.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
